// File: rtl/subleq_pkg.sv
// subleq_pkg: shared word width, memory-op encoding and memory FSM states.
package subleq_pkg;
  localparam int WORD_W = 64;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} mem_state_t;
endpackage

// File: rtl/subleq_mem_if.sv
// subleq_mem_if: CPU memory port, loader stream and status bundled between host and memory.
interface subleq_mem_if;
  import subleq_pkg::*;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_write_bytes;
  logic [WORD_W-1:0] mem_data;
  logic [WORD_W-1:0] load_data;
  logic mem_op;
  logic cpu_reset;
  logic load_valid;
  logic load_last;
  logic load_ready;
  logic run;
  logic oob_err;
  modport slave (
    input mem_addr, mem_op, mem_write_bytes, load_valid, load_data, load_last,
    output mem_data, cpu_reset, load_ready, run, oob_err
  );
  modport master (
    output mem_addr, mem_op, mem_write_bytes, load_valid, load_data, load_last,
    input mem_data, cpu_reset, load_ready, run, oob_err
  );
endinterface

// File: rtl/subleq_ram.sv
// subleq_ram: DEPTH x 64 array with one synchronous write port and one asynchronous read port.
module subleq_ram
  import subleq_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/subleq_mem.sv
// subleq_mem: zero-fills memory, loads a program image, then serves the CPU port and owns its reset.
module subleq_mem
  import subleq_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        reset_n,
  subleq_mem_if.slave bus
);
  localparam logic [1:0] ST_CLEAR = CLEAR;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_RUN = RUN;
  logic [1:0]        r_state;
  logic [AW:0]       r_cnt;
  logic [AW-1:0]     r_ptr;
  logic              r_cpu_reset;
  logic              r_oob;
  logic              w_in_range;
  logic              w_accept;
  logic              w_final;
  logic              w_clear_done;
  logic              w_cpu_wr;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;
  // Full 64-bit compare so high address bits never alias into the array.
  assign w_in_range = bus.mem_addr < WORD_W'(DEPTH);
  assign w_accept = r_state == ST_LOAD && bus.load_valid;
  assign w_final = w_accept && (bus.load_last || r_ptr == AW'(DEPTH - 1));
  assign w_clear_done = r_state == ST_CLEAR && r_cnt == (AW + 1)'(DEPTH - 1);
  assign w_cpu_wr = r_state == ST_RUN && bus.mem_op == MEM_WRITE && w_in_range;
  assign w_we = r_state == ST_CLEAR || w_accept || w_cpu_wr;
  assign w_waddr = r_state == ST_CLEAR ? r_cnt[AW-1:0] : r_state == ST_LOAD ? r_ptr : bus.mem_addr[AW-1:0];
  assign w_wdata = r_state == ST_CLEAR ? '0 : r_state == ST_LOAD ? bus.load_data : bus.mem_write_bytes;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_cnt <= '0;
      r_ptr <= '0;
      r_cpu_reset <= 1'b1;
      r_oob <= 1'b0;
    end else begin
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + 1'b1;
      if (w_clear_done) begin
        r_state <= ST_LOAD;
        r_ptr <= '0;
      end
      if (w_accept) r_ptr <= r_ptr + 1'b1;
      if (w_final) begin
        r_state <= ST_RUN;
        r_cpu_reset <= 1'b0;
      end
      if (r_state == ST_RUN && !w_in_range) r_oob <= 1'b1;
    end
  end
  subleq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(bus.mem_addr[AW-1:0]),
    .o_rdata(w_rdata)
  );
  assign bus.mem_data = (r_state == ST_RUN && w_in_range) ? w_rdata : '0;
  assign bus.load_ready = r_state == ST_LOAD;
  assign bus.run = r_state == ST_RUN;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.oob_err = r_oob;
endmodule
